gc_trap_sequencer: RTL and testbench
====================================

# gc_trap_sequencer

Parametrised global-control trap sequencer that sits beside retire and owns every pipeline-wide flush. It arbitrates N exception sources against the oldest retiring ID, serialises MRET/SRET/FENCE.I, and drains the back end before taking an interrupt, with an optional drain timeout. It drives the registered fetch/issue/retire holds, the writeback suppress, the PC override and the memory-queue flush.

## Interface
- NUM_SOURCES, 4, exception sources (≥1)
- ID_W, 3, instruction-ID width
- COUNT_W, 4, width of post_issue_count
- INIT_CLEAR_DEPTH, 64, cycles spent in post-reset clear (power of two, ≥2)
- DRAIN_TIMEOUT, 32, interrupt drain limit in cycles (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- exc_valid  in  NUM_SOURCES  per-source exception pending
- exc_id  in  NUM_SOURCES*ID_W  per-source faulting ID, source i at [i*ID_W +: ID_W]
- exc_code  in  NUM_SOURCES*5  per-source cause code
- exc_tval  in  NUM_SOURCES*32  per-source trap value
- exc_ack  out  NUM_SOURCES  one-hot acknowledge of the selected source
- retire_id_next  in  ID_W  oldest in-flight ID
- retire_id_valid  in  1  retire_id_next is valid
- issue_valid  in  1  instruction issued to this unit this cycle
- issue_is_ret, issue_is_ifence  in  1 each  op type, sampled with issue_valid
- issue_pc_p4  in  32  PC+4 of the issued op
- interrupt_pending  in  1  enabled interrupt pending
- post_issue_count  in  COUNT_W  issued, not-yet-retired ops
- lsq_empty  in  1  load/store queue holds no committed ops
- exception_target_pc, epc  in  32 each  trap vector / return address
- trap_valid  out  1  trap taken this cycle (comb)
- trap_code  out  5, trap_tval  out  32  selected source's code/tval (comb)
- interrupt_take, ret_taken, intr_timeout  out  1 each  single-cycle pulses (comb)
- fetch_hold, issue_hold, retire_hold, writeback_suppress, init_clear, pc_override, memq_flush  out  1 each  registered controls
- pc_out  out  32  override target (registered)

## Operation
- Source select: match[i] = exc_valid[i] & retire_id_valid & (exc_id[i]==retire_id_next); lowest matching index wins. trap_valid = |match; exc_ack is one-hot of winner when trap_valid, else 0.
- States: RESET, INIT_CLEAR, IDLE, SER_DRAIN, FLUSH, DISCARD, INTR_DRAIN, INTR_TAKE. post_idle = (post_issue_count==0) & lsq_empty.
- RESET→INIT_CLEAR. INIT_CLEAR→IDLE after exactly INIT_CLEAR_DEPTH cycles.
- IDLE: trap_valid→FLUSH; else interrupt_pending→INTR_DRAIN; else issue_valid & (is_ret|is_ifence)→SER_DRAIN (op type and pc_p4 captured).
- SER_DRAIN: trap_valid→FLUSH (captured op dropped, no ret_taken); else post_idle→FLUSH with ret_taken pulse if op was ret.
- FLUSH→DISCARD. DISCARD→IDLE when post_idle; memq_flush pulses for one cycle on that transition.
- INTR_DRAIN, priority order: post_idle→INTR_TAKE; trap_valid→FLUSH; !interrupt_pending→IDLE; timeout→IDLE with intr_timeout.
- INTR_TAKE→IDLE; interrupt_take = (next_state==INTR_TAKE).
- pc_out: exception_target_pc if trap or INTR_TAKE; else captured pc_p4 for ifence; else epc.
- Illegal state → RESET.

## Timing
- Registered controls load from next_state; visible one cycle after the deciding cycle.
- fetch_hold: next_state ∈ {INIT_CLEAR, SER_DRAIN, FLUSH, INTR_DRAIN}. issue_hold: all states except IDLE. retire_hold: next_state ∈ {FLUSH, INTR_TAKE}. writeback_suppress: {INIT_CLEAR, DISCARD}. init_clear: {INIT_CLEAR}. pc_override: {FLUSH, INTR_TAKE}.
- Reset values: state RESET, fetch_hold=1, issue_hold=1, all other registered outputs 0, counters 0, pc_out 0.
- rst mid-operation aborts any sequence next cycle; no pulse emitted.
- Trap and interrupt in the same IDLE cycle: trap wins.

## Configuration
- GC_INTR_DRAIN_TIMEOUT_EN defined: counter clears on INTR_DRAIN entry, increments each INTR_DRAIN cycle; at DRAIN_TIMEOUT cycles without post_idle/trap/deassert → IDLE, intr_timeout pulses.
- Undefined: no counter; INTR_DRAIN waits indefinitely; intr_timeout tied 0.

## Test plan
- Reset release → init_clear high exactly 64 cycles, fetch_hold/issue_hold held, then all low in IDLE.
- Sources 1 and 3 valid, both id=5, retire_id_next=5 → trap_valid, exc_ack=4'b0010, code/tval of source 1; pc_override=1 next cycle, pc_out=exception_target_pc.
- MRET issued, post_issue_count 2→0 over 3 cycles with lsq_empty → ret_taken pulse, pc_out=epc, memq_flush one cycle on DISCARD exit.
- FENCE.I at pc_p4=0x104 while trap on oldest ID → FLUSH to trap vector, no ret_taken, pc_out≠0x104.
- interrupt_pending held, post_issue_count stuck at 1 → with macro: intr_timeout after 32 cycles, back to IDLE; without: stays INTR_DRAIN.
- interrupt_pending drops during INTR_DRAIN → IDLE, no interrupt_take.

Source files
------------

// File: rtl/gc_trap_sequencer.sv
// rtl/gc_trap_sequencer.sv - global-control trap sequencer owning all pipeline-wide flushes
// Optional feature macro: GC_INTR_DRAIN_TIMEOUT_EN (bounds the interrupt drain wait).
module gc_trap_sequencer #(
  parameter int NUM_SOURCES      = 4,
  parameter int ID_W             = 3,
  parameter int COUNT_W          = 4,
  parameter int INIT_CLEAR_DEPTH = 64,
  parameter int DRAIN_TIMEOUT    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SOURCES-1:0]    exc_valid,
  input  logic [NUM_SOURCES*ID_W-1:0] exc_id,
  input  logic [NUM_SOURCES*5-1:0]  exc_code,
  input  logic [NUM_SOURCES*32-1:0] exc_tval,
  output logic [NUM_SOURCES-1:0]    exc_ack,
  input  logic [ID_W-1:0]           retire_id_next,
  input  logic                      retire_id_valid,
  input  logic                      issue_valid,
  input  logic                      issue_is_ret,
  input  logic                      issue_is_ifence,
  input  logic [31:0]               issue_pc_p4,
  input  logic                      interrupt_pending,
  input  logic [COUNT_W-1:0]        post_issue_count,
  input  logic                      lsq_empty,
  input  logic [31:0]               exception_target_pc,
  input  logic [31:0]               epc,
  output logic                      trap_valid,
  output logic [4:0]                trap_code,
  output logic [31:0]               trap_tval,
  output logic                      interrupt_take,
  output logic                      ret_taken,
  output logic                      intr_timeout,
  output logic                      fetch_hold,
  output logic                      issue_hold,
  output logic                      retire_hold,
  output logic                      writeback_suppress,
  output logic                      init_clear,
  output logic                      pc_override,
  output logic                      memq_flush,
  output logic [31:0]               pc_out
);

  localparam int IC_W = $clog2(INIT_CLEAR_DEPTH);

  typedef enum logic [2:0] {
    S_RESET, S_INIT_CLEAR, S_IDLE, S_SER_DRAIN,
    S_FLUSH, S_DISCARD, S_INTR_DRAIN, S_INTR_TAKE
  } state_t;

  state_t            state, next_state;
  logic [IC_W-1:0]   init_cnt;
  logic              cap_is_ret, cap_is_ifence;
  logic [31:0]       cap_pc;
  logic              post_idle;
  logic              timeout_hit;
  logic              ret_fire, tmo_fire;

  assign post_idle = (post_issue_count == '0) && lsq_empty;

`ifdef GC_INTR_DRAIN_TIMEOUT_EN
  localparam int DT_W = $clog2(DRAIN_TIMEOUT);
  logic [DT_W-1:0] drain_cnt;
  assign timeout_hit = (drain_cnt == DT_W'(DRAIN_TIMEOUT - 1));

  // Drain counter restarts on every INTR_DRAIN entry and counts cycles spent there
  always_ff @(posedge clk) begin
    if (rst || state != S_INTR_DRAIN) drain_cnt <= '0;
    else                              drain_cnt <= drain_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Source arbitration against the oldest retiring ID; lowest index wins
  always_comb begin
    trap_valid = 1'b0;
    exc_ack    = '0;
    trap_code  = '0;
    trap_tval  = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (exc_valid[i] && retire_id_valid && (exc_id[i*ID_W +: ID_W] == retire_id_next)) begin
        trap_valid = 1'b1;
        exc_ack    = '0;
        exc_ack[i] = 1'b1;
        trap_code  = exc_code[i*5 +: 5];
        trap_tval  = exc_tval[i*32 +: 32];
      end
    end
  end

  // Next-state decision plus the single-cycle pulses tied to specific transitions
  always_comb begin
    next_state = state;
    ret_fire   = 1'b0;
    tmo_fire   = 1'b0;
    if (rst) begin
      next_state = S_RESET;
    end else begin
      case (state)
        S_RESET:      next_state = S_INIT_CLEAR;
        S_INIT_CLEAR: if (init_cnt == IC_W'(INIT_CLEAR_DEPTH - 1)) next_state = S_IDLE;
        S_IDLE: begin
          if (trap_valid)                                             next_state = S_FLUSH;
          else if (interrupt_pending)                                 next_state = S_INTR_DRAIN;
          else if (issue_valid && (issue_is_ret || issue_is_ifence))  next_state = S_SER_DRAIN;
        end
        S_SER_DRAIN: begin
          if (trap_valid) next_state = S_FLUSH;
          else if (post_idle) begin
            next_state = S_FLUSH;
            ret_fire   = cap_is_ret;
          end
        end
        S_FLUSH:      next_state = S_DISCARD;
        S_DISCARD:    if (post_idle) next_state = S_IDLE;
        S_INTR_DRAIN: begin
          if (post_idle)               next_state = S_INTR_TAKE;
          else if (trap_valid)         next_state = S_FLUSH;
          else if (!interrupt_pending) next_state = S_IDLE;
          else if (timeout_hit) begin
            next_state = S_IDLE;
            tmo_fire   = 1'b1;
          end
        end
        S_INTR_TAKE:  next_state = S_IDLE;
        default:      next_state = S_RESET;
      endcase
    end
  end

  assign ret_taken      = ret_fire;
  assign intr_timeout   = tmo_fire;
  assign interrupt_take = (next_state == S_INTR_TAKE);

  // State, capture registers and registered controls all load from next_state
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_RESET;
      init_cnt           <= '0;
      cap_is_ret         <= 1'b0;
      cap_is_ifence      <= 1'b0;
      cap_pc             <= '0;
      fetch_hold         <= 1'b1;
      issue_hold         <= 1'b1;
      retire_hold        <= 1'b0;
      writeback_suppress <= 1'b0;
      init_clear         <= 1'b0;
      pc_override        <= 1'b0;
      memq_flush         <= 1'b0;
      pc_out             <= '0;
    end else begin
      state    <= next_state;
      init_cnt <= (state == S_INIT_CLEAR) ? init_cnt + 1'b1 : '0;
      if (state == S_IDLE && next_state == S_SER_DRAIN) begin
        cap_is_ret    <= issue_is_ret;
        cap_is_ifence <= issue_is_ifence && !issue_is_ret;
        cap_pc        <= issue_pc_p4;
      end
      fetch_hold         <= (next_state == S_INIT_CLEAR) || (next_state == S_SER_DRAIN) ||
                            (next_state == S_FLUSH) || (next_state == S_INTR_DRAIN);
      issue_hold         <= (next_state != S_IDLE);
      retire_hold        <= (next_state == S_FLUSH) || (next_state == S_INTR_TAKE);
      writeback_suppress <= (next_state == S_INIT_CLEAR) || (next_state == S_DISCARD);
      init_clear         <= (next_state == S_INIT_CLEAR);
      pc_override        <= (next_state == S_FLUSH) || (next_state == S_INTR_TAKE);
      memq_flush         <= (state == S_DISCARD) && (next_state == S_IDLE);
      if (next_state == S_FLUSH || next_state == S_INTR_TAKE) begin
        if (trap_valid || next_state == S_INTR_TAKE) pc_out <= exception_target_pc;
        else if (cap_is_ifence)                      pc_out <= cap_pc;
        else                                         pc_out <= epc;
      end
    end
  end

endmodule

// File: tb/tb_gc_trap_sequencer.sv
// tb/tb_gc_trap_sequencer.sv - self-checking bench for gc_trap_sequencer
module tb_gc_trap_sequencer;

  localparam int NS  = 4;
  localparam int IDW = 3;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   exc_valid;
  logic [NS*IDW-1:0] exc_id;
  logic [NS*5-1:0] exc_code;
  logic [NS*32-1:0] exc_tval;
  logic [NS-1:0]   exc_ack;
  logic [IDW-1:0]  retire_id_next;
  logic            retire_id_valid;
  logic            issue_valid, issue_is_ret, issue_is_ifence;
  logic [31:0]     issue_pc_p4;
  logic            interrupt_pending;
  logic [CW-1:0]   post_issue_count;
  logic            lsq_empty;
  logic [31:0]     exception_target_pc, epc;
  logic            trap_valid;
  logic [4:0]      trap_code;
  logic [31:0]     trap_tval;
  logic            interrupt_take, ret_taken, intr_timeout;
  logic            fetch_hold, issue_hold, retire_hold, writeback_suppress;
  logic            init_clear, pc_override, memq_flush;
  logic [31:0]     pc_out;

  gc_trap_sequencer dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_id(exc_id), .exc_code(exc_code), .exc_tval(exc_tval),
    .exc_ack(exc_ack), .retire_id_next(retire_id_next), .retire_id_valid(retire_id_valid),
    .issue_valid(issue_valid), .issue_is_ret(issue_is_ret), .issue_is_ifence(issue_is_ifence),
    .issue_pc_p4(issue_pc_p4), .interrupt_pending(interrupt_pending),
    .post_issue_count(post_issue_count), .lsq_empty(lsq_empty),
    .exception_target_pc(exception_target_pc), .epc(epc),
    .trap_valid(trap_valid), .trap_code(trap_code), .trap_tval(trap_tval),
    .interrupt_take(interrupt_take), .ret_taken(ret_taken), .intr_timeout(intr_timeout),
    .fetch_hold(fetch_hold), .issue_hold(issue_hold), .retire_hold(retire_hold),
    .writeback_suppress(writeback_suppress), .init_clear(init_clear),
    .pc_override(pc_override), .memq_flush(memq_flush), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NS-1:0]     ev;
    logic [NS*IDW-1:0] ids;
    logic [IDW-1:0]    rid;
    logic              rv;
    int                win;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (issue_hold !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk("reach_idle", {31'd0, issue_hold}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ic;
    int first;
    int itake;
    int mq;
    logic [NS-1:0] exp_ack;
    logic [4:0]    exp_code;
    logic [31:0]   exp_tval;

    tbl[0] = '{4'b0000, 12'h000, 3'd0, 1'b1, -1};
    tbl[1] = '{4'b1010, {3'd5, 3'd0, 3'd5, 3'd0}, 3'd5, 1'b1, 1};
    tbl[2] = '{4'b1010, {3'd5, 3'd0, 3'd5, 3'd0}, 3'd5, 1'b0, -1};
    tbl[3] = '{4'b0101, {3'd0, 3'd5, 3'd0, 3'd2}, 3'd5, 1'b1, 2};
    tbl[4] = '{4'b1111, {3'd7, 3'd7, 3'd7, 3'd7}, 3'd7, 1'b1, 0};
    tbl[5] = '{4'b1000, {3'd6, 3'd0, 3'd0, 3'd0}, 3'd6, 1'b1, 3};
    tbl[6] = '{4'b0010, {3'd0, 3'd0, 3'd4, 3'd0}, 3'd5, 1'b1, -1};
    tbl[7] = '{4'b1100, {3'd1, 3'd1, 3'd0, 3'd1}, 3'd1, 1'b1, 2};

    for (int i = 0; i < NS; i++) begin
      exc_code[i*5 +: 5]   = 5'h10 + 5'(i);
      exc_tval[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
    rst = 1'b1;
    exc_valid = '0; exc_id = '0; retire_id_next = '0; retire_id_valid = 1'b0;
    issue_valid = 1'b0; issue_is_ret = 1'b0; issue_is_ifence = 1'b0; issue_pc_p4 = '0;
    interrupt_pending = 1'b0; post_issue_count = '0; lsq_empty = 1'b1;
    exception_target_pc = 32'h8000_0100; epc = 32'h0000_2000;

    // Reset state
    step(); step();
    chk("rst_fetch_hold", {31'd0, fetch_hold}, 32'd1);
    chk("rst_issue_hold", {31'd0, issue_hold}, 32'd1);
    chk("rst_init_clear", {31'd0, init_clear}, 32'd0);
    chk("rst_pc_override", {31'd0, pc_override}, 32'd0);
    chk("rst_wb_suppress", {31'd0, writeback_suppress}, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);

    // Init clear window, with the arbitration table applied while the FSM ignores traps
    rst = 1'b0;
    ic = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (c < 8) begin
        exc_valid = tbl[c].ev; exc_id = tbl[c].ids;
        retire_id_next = tbl[c].rid; retire_id_valid = tbl[c].rv;
        #1;
        exp_ack  = (tbl[c].win >= 0) ? NS'(1) << tbl[c].win : '0;
        exp_code = (tbl[c].win >= 0) ? 5'h10 + 5'(tbl[c].win) : 5'h0;
        exp_tval = (tbl[c].win >= 0) ? 32'hA000_0000 + 32'(tbl[c].win) : 32'h0;
        chk($sformatf("arb%0d_trap_valid", c), {31'd0, trap_valid}, {31'd0, tbl[c].win >= 0});
        chk($sformatf("arb%0d_ack", c), {28'd0, exc_ack}, {28'd0, exp_ack});
        chk($sformatf("arb%0d_code", c), {27'd0, trap_code}, {27'd0, exp_code});
        chk($sformatf("arb%0d_tval", c), trap_tval, exp_tval);
      end else begin
        exc_valid = '0; retire_id_valid = 1'b0;
      end
      if (init_clear === 1'b1) begin
        ic++;
        if (fetch_hold !== 1'b1 || issue_hold !== 1'b1)
          chk("init_holds", {30'd0, fetch_hold, issue_hold}, 32'd3);
      end
      if (issue_hold === 1'b0) break;
    end
    chk("init_clear_cycles", ic, 64);
    chk("idle_fetch_hold", {31'd0, fetch_hold}, 32'd0);
    chk("idle_issue_hold", {31'd0, issue_hold}, 32'd0);
    chk("idle_init_clear", {31'd0, init_clear}, 32'd0);
    chk("idle_wb_suppress", {31'd0, writeback_suppress}, 32'd0);

    // Trap from IDLE: sources 1 and 3 both match, source 1 wins
    exc_valid = 4'b1010; exc_id = {3'd5, 3'd0, 3'd5, 3'd0};
    retire_id_next = 3'd5; retire_id_valid = 1'b1;
    #1;
    chk("trap_valid", {31'd0, trap_valid}, 32'd1);
    chk("trap_ack", {28'd0, exc_ack}, 32'b0010);
    chk("trap_code", {27'd0, trap_code}, 32'h11);
    step();
    exc_valid = '0;
    chk("trap_pc_override", {31'd0, pc_override}, 32'd1);
    chk("trap_pc_out", pc_out, 32'h8000_0100);
    chk("trap_retire_hold", {31'd0, retire_hold}, 32'd1);
    step();
    chk("discard_wb_suppress", {31'd0, writeback_suppress}, 32'd1);
    step();
    chk("trap_memq_flush", {31'd0, memq_flush}, 32'd1);
    chk("trap_back_idle", {31'd0, issue_hold}, 32'd0);
    step();
    chk("trap_memq_flush_off", {31'd0, memq_flush}, 32'd0);

    // MRET serialised behind a draining back end
    issue_valid = 1'b1; issue_is_ret = 1'b1; issue_pc_p4 = 32'h3004; post_issue_count = 4'd2;
    step();
    chk("mret_fetch_hold", {31'd0, fetch_hold}, 32'd1);
    issue_valid = 1'b0; issue_is_ret = 1'b0;
    #1 chk("mret_ret_c2", {31'd0, ret_taken}, 32'd0);
    step(); post_issue_count = 4'd1;
    #1 chk("mret_ret_c1", {31'd0, ret_taken}, 32'd0);
    step(); post_issue_count = 4'd0;
    #1 chk("mret_ret_pulse", {31'd0, ret_taken}, 32'd1);
    step();
    chk("mret_ret_off", {31'd0, ret_taken}, 32'd0);
    chk("mret_pc_override", {31'd0, pc_override}, 32'd1);
    chk("mret_pc_out", pc_out, 32'h0000_2000);
    mq = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (memq_flush === 1'b1) mq++;
    end
    chk("mret_memq_pulses", mq, 1);
    chk("mret_idle", {31'd0, issue_hold}, 32'd0);

    // FENCE.I overtaken by a trap on the oldest ID
    issue_valid = 1'b1; issue_is_ifence = 1'b1; issue_pc_p4 = 32'h104; post_issue_count = 4'd1;
    step();
    issue_valid = 1'b0; issue_is_ifence = 1'b0;
    exc_valid = 4'b0001; exc_id = {3'd0, 3'd0, 3'd0, 3'd3}; retire_id_next = 3'd3;
    #1;
    chk("ifence_trap_valid", {31'd0, trap_valid}, 32'd1);
    chk("ifence_trap_no_ret", {31'd0, ret_taken}, 32'd0);
    step();
    exc_valid = '0; post_issue_count = 4'd0;
    chk("ifence_trap_pc_out", pc_out, 32'h8000_0100);
    wait_idle();

    // FENCE.I alone resumes at its own PC+4
    issue_valid = 1'b1; issue_is_ifence = 1'b1; issue_pc_p4 = 32'h204;
    step();
    issue_valid = 1'b0; issue_is_ifence = 1'b0;
    #1 chk("ifence_no_ret", {31'd0, ret_taken}, 32'd0);
    step();
    chk("ifence_pc_out", pc_out, 32'h204);
    wait_idle();

    // Interrupt drain with the back end stuck non-empty
    interrupt_pending = 1'b1; post_issue_count = 4'd1;
    step();
    first = -1; itake = 0;
    for (int k = 0; k < 40; k++) begin
      if (interrupt_take === 1'b1) itake++;
      if (intr_timeout === 1'b1) begin
        first = k;
        break;
      end
      step();
    end
    chk("stuck_no_take", itake, 0);
`ifdef GC_INTR_DRAIN_TIMEOUT_EN
    chk("timeout_cycle", first, 31);
    step();
    chk("timeout_idle", {31'd0, issue_hold}, 32'd0);
`else
    chk("no_timeout", first, -1);
    chk("drain_holds", {31'd0, fetch_hold}, 32'd1);
`endif
    interrupt_pending = 1'b0; post_issue_count = 4'd0;
    wait_idle();

    // Interrupt withdrawn mid-drain
    interrupt_pending = 1'b1; post_issue_count = 4'd1;
    step(); step(); step();
    interrupt_pending = 1'b0;
    #1 chk("withdraw_no_take", {31'd0, interrupt_take}, 32'd0);
    step();
    chk("withdraw_idle", {31'd0, issue_hold}, 32'd0);
    chk("withdraw_no_retire_hold", {31'd0, retire_hold}, 32'd0);
    post_issue_count = 4'd0;

    // Interrupt taken once drained
    exception_target_pc = 32'h8000_0200;
    interrupt_pending = 1'b1;
    #1 chk("intr_idle_no_take", {31'd0, interrupt_take}, 32'd0);
    step();
    #1 chk("intr_take_pulse", {31'd0, interrupt_take}, 32'd1);
    step();
    interrupt_pending = 1'b0;
    chk("intr_pc_override", {31'd0, pc_override}, 32'd1);
    chk("intr_retire_hold", {31'd0, retire_hold}, 32'd1);
    chk("intr_pc_out", pc_out, 32'h8000_0200);
    step();
    chk("intr_idle", {31'd0, issue_hold}, 32'd0);

    // Reset during a serialised MRET drops the pending return
    issue_valid = 1'b1; issue_is_ret = 1'b1; post_issue_count = 4'd1;
    step();
    issue_valid = 1'b0; issue_is_ret = 1'b0; post_issue_count = 4'd0; rst = 1'b1;
    #1 chk("rst_mid_no_ret", {31'd0, ret_taken}, 32'd0);
    step();
    chk("rst_mid_fetch_hold", {31'd0, fetch_hold}, 32'd1);
    chk("rst_mid_issue_hold", {31'd0, issue_hold}, 32'd1);
    chk("rst_mid_pc_override", {31'd0, pc_override}, 32'd0);
    chk("rst_mid_pc_out", pc_out, 32'd0);
    rst = 1'b0;
    wait_idle();
    chk("rst_mid_init_done", {31'd0, init_clear}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
